// File: rtl/ucsbece154b_pkg.sv
// Shared types and constants for the instruction prefetch stage.
package ucsbece154b_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic {
        S_RUN,
        S_DRAIN
    } prefetch_state_e;

    // Layout of one FIFO entry as produced with the default 32-bit widths.
    typedef struct packed {
        logic        epoch;
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ucsbece154b_prefetch.sv
// Instruction prefetch: issues sequential fetches, tags responses with
// {epoch, pc} and pushes them into the downstream FIFO. Credits bound the
// number of words that can be in flight or buffered to the FIFO depth.
module ucsbece154b_prefetch
    import ucsbece154b_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           NR_ENTRIES      = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush_i,
    input  logic [ADDR_WIDTH-1:0]            flush_pc_i,
    output logic                             mem_req_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    input  logic                             mem_gnt_i,
    input  logic                             mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_i,
    output logic                             fifo_push_o,
    output logic [ADDR_WIDTH+DATA_WIDTH:0]   fifo_data_o,
    input  logic                             fifo_pop_i
);

    localparam int unsigned CW = $clog2(NR_ENTRIES + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    prefetch_state_e       state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         credit_q, credit_d;
    logic [OW-1:0]         outst_q, outst_d;
    logic [OW-1:0]         kill_cnt_q, kill_cnt_d;
    logic                  epoch_q, epoch_d;

    logic req;
    logic gnt;
    logic drop;
    logic push;

    // Next-state, request/push generation and credit/outstanding accounting.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        credit_d   = credit_q;
        outst_d    = outst_q;
        kill_cnt_d = kill_cnt_q;
        epoch_d    = epoch_q;

        req  = !rst && (state_q == S_RUN) && !flush_i &&
               (credit_q != '0) && (outst_q < OW'(MAX_OUTSTANDING));
        gnt  = req && mem_gnt_i;
        // A response is discarded if it belongs to a killed request or
        // arrives in the same cycle as a redirect.
        drop = mem_rvalid_i && (flush_i || (kill_cnt_q != '0));
        push = !rst && mem_rvalid_i && !drop;

        credit_d = credit_q - CW'(gnt) + CW'(drop) + CW'(fifo_pop_i);
        outst_d  = outst_q + OW'(gnt) - OW'(mem_rvalid_i);

        if (gnt)  pc_d     = pc_q + ADDR_WIDTH'(INSTR_BYTES);
        if (push) rsp_pc_d = rsp_pc_q + ADDR_WIDTH'(INSTR_BYTES);

        if (flush_i) begin
            pc_d       = flush_pc_i;
            rsp_pc_d   = flush_pc_i;
            epoch_d    = ~epoch_q;
            kill_cnt_d = outst_q - OW'(mem_rvalid_i);
            state_d    = (kill_cnt_d != '0) ? S_DRAIN : S_RUN;
        end else begin
            if (drop) kill_cnt_d = kill_cnt_q - OW'(1);
            if ((state_q == S_DRAIN) && (kill_cnt_d == '0)) state_d = S_RUN;
        end

        mem_req_o   = req;
        mem_addr_o  = pc_q;
        fifo_push_o = push;
        fifo_data_o = {epoch_q, rsp_pc_q, mem_rdata_i};
    end

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            credit_q   <= CW'(NR_ENTRIES);
            outst_q    <= '0;
            kill_cnt_q <= '0;
            epoch_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            credit_q   <= credit_d;
            outst_q    <= outst_d;
            kill_cnt_q <= kill_cnt_d;
            epoch_q    <= epoch_d;
        end
    end

    // A response with nothing outstanding means the memory broke protocol.
    rvalid_without_request: assert property (
        @(posedge clk) disable iff (rst) mem_rvalid_i |-> (outst_q != '0)
    );

endmodule

// File: tb/tb_ucsbece154b_prefetch.sv
// Directed bench: an in-order memory responder with programmable latency
// feeds the prefetcher; every cycle is checked against hand-derived values.
module tb_ucsbece154b_prefetch;
    import ucsbece154b_pkg::*;

    localparam logic [31:0] RKEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i = 1'b1;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        fifo_push_o;
    logic [64:0] fifo_data_o;
    logic        fifo_pop_i = 1'b0;

    ucsbece154b_prefetch #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NR_ENTRIES(4),
        .MAX_OUTSTANDING(2), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .fifo_push_o(fifo_push_o), .fifo_data_o(fifo_data_o),
        .fifo_pop_i(fifo_pop_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t q[$];
    int    cyc = 0;
    int    lat = 1;
    int    occ = 0;
    int    total = 0;
    int    bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            rst = 1'b1; flush_i = 1'b0; fifo_pop_i = 1'b0; mem_rvalid_i = 1'b0;
            #1;
            chk("rst_req", 64'(mem_req_o), 64'd0);
            chk("rst_push", 64'(fifo_push_o), 64'd0);
        end
        q.delete();
        occ = 0;
        cyc = 0;
    endtask

    // One clock cycle: drive inputs, respond from the memory model, check outputs.
    task automatic tick(input logic f, input logic [31:0] fpc, input logic pop,
                        input logic ereq, input logic [31:0] eaddr,
                        input logic epush, input logic eep, input logic [31:0] epc);
        fetch_entry_t ent;
        pend_t        p;
        @(posedge clk); #1;
        rst = 1'b0; flush_i = f; flush_pc_i = fpc; fifo_pop_i = pop; mem_gnt_i = 1'b1;
        if (q.size() > 0 && q[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = q[0].addr ^ RKEY;
        end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
        end
        #1;
        ent = fifo_data_o;
        chk("req", 64'(mem_req_o), 64'(ereq));
        if (ereq) chk("addr", 64'(mem_addr_o), 64'(eaddr));
        chk("push", 64'(fifo_push_o), 64'(epush));
        if (epush) begin
            chk("pc", 64'(ent.pc), 64'(epc));
            chk("epoch", 64'(ent.epoch), 64'(eep));
            chk("instr", 64'(ent.instr), 64'(epc ^ RKEY));
        end
        if (fifo_push_o) chk("fifo_room", 64'(occ < 4), 64'd1);
        if (mem_req_o && mem_gnt_i) begin
            p.addr = mem_addr_o;
            p.due  = cyc + lat;
            q.push_back(p);
        end
        if (mem_rvalid_i) void'(q.pop_front());
        occ = occ + int'(fifo_push_o) - int'(fifo_pop_i);
        cyc++;
    endtask

    initial begin
        // Fill: latency 1, no pops, credit runs out after four grants.
        lat = 1;
        do_reset(2);
        tick(0, 0, 0, 1, 32'h0,  0, 0, 0);
        tick(0, 0, 0, 1, 32'h4,  1, 0, 32'h0);
        tick(0, 0, 0, 1, 32'h8,  1, 0, 32'h4);
        tick(0, 0, 0, 1, 32'hC,  1, 0, 32'h8);
        tick(0, 0, 0, 0, 32'h0,  1, 0, 32'hC);
        tick(0, 0, 0, 0, 32'h0,  0, 0, 0);
        // Pops return credit one at a time.
        tick(0, 0, 1, 0, 32'h0,  0, 0, 0);
        tick(0, 0, 1, 1, 32'h10, 0, 0, 0);
        tick(0, 0, 1, 1, 32'h14, 1, 0, 32'h10);
        tick(0, 0, 1, 1, 32'h18, 1, 0, 32'h14);
        tick(0, 0, 0, 1, 32'h1C, 1, 0, 32'h18);
        tick(0, 0, 0, 0, 32'h0,  1, 0, 32'h1C);
        tick(0, 0, 0, 0, 32'h0,  0, 0, 0);

        // Latency 5: outstanding limit of two throttles requests.
        lat = 5;
        do_reset(1);
        tick(0, 0, 0, 1, 32'h0, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h4, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 32'h0, 0, 0, 0);
        tick(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        tick(0, 0, 0, 1, 32'h8, 1, 0, 32'h4);
        tick(0, 0, 0, 1, 32'hC, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 32'h0, 0, 0, 0);
        tick(0, 0, 0, 0, 32'h0, 1, 0, 32'h8);
        tick(0, 0, 0, 0, 32'h0, 1, 0, 32'hC);

        // Flush with two outstanding, no response in the flush cycle.
        lat = 5;
        do_reset(1);
        tick(0, 0, 0, 1, 32'h0, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h4, 0, 0, 0);
        tick(1, 32'h100, 0, 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 32'h0, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h100, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h104, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 32'h0, 0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   1, 1, 32'h100);
        tick(0, 0, 0, 1, 32'h108, 1, 1, 32'h104);
        tick(0, 0, 0, 1, 32'h10C, 0, 0, 0);

        // Flush coincident with a response and one more outstanding.
        lat = 2;
        do_reset(1);
        tick(0, 0, 0, 1, 32'h0, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h4, 0, 0, 0);
        tick(1, 32'h200, 0, 0, 32'h0, 0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   0, 0, 0);
        tick(0, 0, 0, 1, 32'h200, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h204, 0, 0, 0);
        tick(0, 0, 0, 0, 32'h0,   1, 1, 32'h200);
        tick(0, 0, 0, 1, 32'h208, 1, 1, 32'h204);

        // Reset while draining with credit 1.
        lat = 2;
        do_reset(1);
        tick(0, 0, 0, 1, 32'h0, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h4, 0, 0, 0);
        tick(0, 0, 0, 0, 32'h0, 1, 0, 32'h0);
        tick(0, 0, 0, 1, 32'h8, 1, 0, 32'h4);
        tick(0, 0, 0, 1, 32'hC, 0, 0, 0);
        tick(1, 32'h300, 0, 0, 32'h0, 0, 0, 0);
        lat = 1;
        do_reset(1);
        tick(0, 0, 0, 1, 32'h0, 0, 0, 0);
        tick(0, 0, 0, 1, 32'h4, 1, 0, 32'h0);
        tick(0, 0, 0, 1, 32'h8, 1, 0, 32'h4);
        tick(0, 0, 0, 1, 32'hC, 1, 0, 32'h8);
        tick(0, 0, 0, 0, 32'h0, 1, 0, 32'hC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
